// File: rtl/load_queue_fu.sv
// load_queue_fu: multi-entry load functional unit.
// Loads are issued into a circular queue. Their effective addresses are
// computed at issue, and one memory read is sent at a time in program order.
// The addressed byte/half/word is extracted and extended, and results retire
// to the CDB in issue order.
//
// Handshakes:
//   issue : a load is taken on a rising edge where issue_valid && issue_ready.
//   memory: the request is taken on a rising edge where mem_req && mem_ack.
//           mem_req/mem_addr/mem_size hold until then. mem_ack alone is ignored.
//   cdb   : the head result is taken on a rising edge where out_valid && out_ack.
//           out_ack alone is ignored.
// Every output is derived only from registered state, so no handshake input
// reaches an output combinationally.
module load_queue_fu #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [XLEN-1:0]            issue_base,
  input  logic [XLEN-1:0]            issue_imm,
  input  logic [2:0]                 issue_funct3,
  input  logic [TAG_W-1:0]           issue_tag,
  output logic                       mem_req,
  output logic [XLEN-1:0]            mem_addr,
  output logic [1:0]                 mem_size,
  input  logic                       mem_ack,
  input  logic [XLEN-1:0]            mem_rdata,
  output logic                       out_valid,
  output logic [TAG_W-1:0]           out_tag,
  output logic [XLEN-1:0]            out_data,
  output logic                       out_excp,
  input  logic                       out_ack,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Per-entry lifecycle: FREE -> PEND (allocated) -> DONE (result ready) -> FREE
  typedef enum logic [1:0] {
    E_FREE = 2'd0,
    E_PEND = 2'd1,
    E_DONE = 2'd2
  } ent_state_t;

  // Entry control state (async reset)
  ent_state_t        r_state [DEPTH];
  logic [PW-1:0]     r_tail;
  logic [PW-1:0]     r_mptr;
  logic [PW-1:0]     r_head;
  logic [CW-1:0]     r_count;

  // Entry payload (written only when an entry is allocated or completes)
  logic [TAG_W-1:0]  r_tag   [DEPTH];
  logic [2:0]        r_f3    [DEPTH];
  logic [XLEN-1:0]   r_addr  [DEPTH];
  logic [XLEN-1:0]   r_data  [DEPTH];
  logic [DEPTH-1:0]  r_excp;

  // Decoded view of the entry at the memory pointer
  ent_state_t        w_m_state;
  logic [2:0]        w_m_f3;
  logic [XLEN-1:0]   w_m_addr;
  logic              w_m_pend;
  logic              w_m_fault;
  logic              w_mem_req;
  logic              w_mem_fire;
  logic              w_m_trap;

  // Queue-level handshake decisions
  logic              w_issue_ready;
  logic              w_alloc;
  logic              w_out_valid;
  logic              w_retire;

  // Load-data extraction
  logic [31:0]       w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic              w_zext;
  logic [XLEN-1:0]   w_ext;
  logic [XLEN-1:0]   w_eff_addr;

  // Only LB, LH, LW, LBU, LHU are loads this unit executes.
  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // Halves need an even address; words need a 4-byte aligned address.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) ||
           ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Decode the entry at mptr: issue a request, or turn a bad load into an exception.
  always_comb begin
    w_m_state  = r_state[r_mptr];
    w_m_f3     = r_f3[r_mptr];
    w_m_addr   = r_addr[r_mptr];
    w_m_pend   = (w_m_state == E_PEND);
    w_m_fault  = !f3_legal(w_m_f3) || misaligned(w_m_f3, w_m_addr[1:0]);
    w_mem_req  = w_m_pend && !w_m_fault;
    w_mem_fire = w_mem_req && mem_ack;
    w_m_trap   = w_m_pend && w_m_fault;
  end

  // Queue occupancy and the issue/retire handshakes.
  always_comb begin
    w_issue_ready = (r_count < CW'(DEPTH));
    w_alloc       = issue_valid && w_issue_ready;
    w_out_valid   = (r_state[r_head] == E_DONE);
    w_retire      = w_out_valid && out_ack;
    w_eff_addr    = issue_base + issue_imm;
  end

  // Select the addressed byte/half/word from the low word and extend to XLEN.
  always_comb begin
    w_word = mem_rdata[31:0];
    w_byte = w_word[{w_m_addr[1:0], 3'b000} +: 8];
    w_half = w_word[{w_m_addr[1], 4'b0000} +: 16];
    w_zext = w_m_f3[2];
    w_ext  = '0;
    case (w_m_f3[1:0])
      2'b00:   w_ext = w_zext ? XLEN'(w_byte) : XLEN'($signed(w_byte));
      2'b01:   w_ext = w_zext ? XLEN'(w_half) : XLEN'($signed(w_half));
      default: w_ext = XLEN'($signed(w_word));
    endcase
  end

  // Outputs; payload fields read as zero whenever the matching valid is low.
  always_comb begin
    issue_ready = w_issue_ready;
    mem_req     = w_mem_req;
    mem_addr    = w_mem_req ? w_m_addr : '0;
    mem_size    = w_mem_req ? w_m_f3[1:0] : 2'b00;
    out_valid   = w_out_valid;
    out_tag     = w_out_valid ? r_tag[r_head] : '0;
    out_data    = w_out_valid ? r_data[r_head] : '0;
    out_excp    = w_out_valid ? r_excp[r_head] : 1'b0;
    count       = r_count;
  end

  // Entry states, pointers and count; flush wins over every other event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= E_FREE;
      end
      r_tail  <= '0;
      r_mptr  <= '0;
      r_head  <= '0;
      r_count <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= E_FREE;
      end
      r_tail  <= '0;
      r_mptr  <= '0;
      r_head  <= '0;
      r_count <= '0;
    end else begin
      // alloc, completion and retire always touch three different entries
      if (w_alloc) begin
        r_state[r_tail] <= E_PEND;
        r_tail          <= ptr_inc(r_tail);
      end
      if (w_mem_fire || w_m_trap) begin
        r_state[r_mptr] <= E_DONE;
        r_mptr          <= ptr_inc(r_mptr);
      end
      if (w_retire) begin
        r_state[r_head] <= E_FREE;
        r_head          <= ptr_inc(r_head);
      end
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload: capture the load on alloc and its result on completion.
  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      if (w_alloc) begin
        r_tag[r_tail]  <= issue_tag;
        r_f3[r_tail]   <= issue_funct3;
        r_addr[r_tail] <= w_eff_addr;
      end
      if (w_mem_fire) begin
        r_data[r_mptr] <= w_ext;
        r_excp[r_mptr] <= 1'b0;
      end else if (w_m_trap) begin
        r_data[r_mptr] <= '0;
        r_excp[r_mptr] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_queue_fu.sv
// tb_load_queue_fu: directed scenarios followed by randomized traffic.
// A queue-based model of the load unit predicts every output each cycle.
module tb_load_queue_fu;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic             issue_valid;
  logic             issue_ready;
  logic [XLEN-1:0]  issue_base;
  logic [XLEN-1:0]  issue_imm;
  logic [2:0]       issue_funct3;
  logic [TAG_W-1:0] issue_tag;
  logic             mem_req;
  logic [XLEN-1:0]  mem_addr;
  logic [1:0]       mem_size;
  logic             mem_ack;
  logic [XLEN-1:0]  mem_rdata;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_data;
  logic             out_excp;
  logic             out_ack;
  logic [CW-1:0]    count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  load_queue_fu #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_base(issue_base), .issue_imm(issue_imm),
    .issue_funct3(issue_funct3), .issue_tag(issue_tag),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_tag(out_tag), .out_data(out_data),
    .out_excp(out_excp), .out_ack(out_ack), .count(count)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [2:0]       f3;
    logic [31:0]      addr;
    bit               done;
    bit               excp;
    logic [31:0]      data;
  } ent_t;

  ent_t exp_q[$];   // loads in program order, oldest first
  int   m_idx = 0;  // how many of them have had their memory step

  function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] a);
    int nb;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    nb = 1 << f3[1:0];
    return (a % nb) == 0;
  endfunction

  function automatic logic [31:0] m_extract(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
    longint nbits, v, span;
    nbits = 8 * (longint'(1) << f3[1:0]);
    span  = longint'(1) << nbits;
    v     = (longint'(rd) >> (8 * (a % 4))) % span;
    if (!f3[2] && v >= (span / 2)) v = v - span;
    return v[31:0];
  endfunction

  // Advance the model at each rising edge using the inputs the DUT also sees.
  always @(posedge clock) begin : model_step
    bit   do_alloc, do_ret;
    ent_t e;
    if (reset || flush) begin
      exp_q.delete();
      m_idx = 0;
    end else begin
      do_alloc = issue_valid && (exp_q.size() < DEPTH);
      do_ret   = (exp_q.size() > 0) && exp_q[0].done && out_ack;
      if (m_idx < exp_q.size()) begin
        e = exp_q[m_idx];
        if (!m_legal(e.f3, e.addr)) begin
          e.done = 1; e.excp = 1; e.data = '0;
          exp_q[m_idx] = e;
          m_idx++;
        end else if (mem_ack) begin
          e.done = 1; e.excp = 0; e.data = m_extract(e.f3, e.addr, mem_rdata);
          exp_q[m_idx] = e;
          m_idx++;
        end
      end
      if (do_ret) begin
        void'(exp_q.pop_front());
        m_idx--;
      end
      if (do_alloc) begin
        e.tag  = issue_tag;
        e.f3   = issue_funct3;
        e.addr = issue_base + issue_imm;
        e.done = 0; e.excp = 0; e.data = '0;
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clock) begin : compare
    int n;
    bit eov, ereq;
    if (chk_en) begin
      n = exp_q.size();
      chk("issue_ready", issue_ready, n < DEPTH);
      chk("count", count, n);
      eov = (n > 0) && exp_q[0].done;
      chk("out_valid", out_valid, eov);
      if (eov) begin
        chk("out_tag", out_tag, exp_q[0].tag);
        chk("out_data", out_data, exp_q[0].data);
        chk("out_excp", out_excp, exp_q[0].excp);
      end
      ereq = 0;
      if (m_idx < n) ereq = m_legal(exp_q[m_idx].f3, exp_q[m_idx].addr);
      chk("mem_req", mem_req, ereq);
      if (ereq) begin
        chk("mem_addr", mem_addr, exp_q[m_idx].addr);
        chk("mem_size", mem_size, exp_q[m_idx].f3[1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic set_issue(input bit v, input logic [31:0] base, input logic [31:0] imm,
                           input logic [2:0] f3, input int tag);
    issue_valid  = v;
    issue_base   = base;
    issue_imm    = imm;
    issue_funct3 = f3;
    issue_tag    = TAG_W'(tag);
  endtask

  logic [31:0]      ext_exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
  logic [TAG_W-1:0] exc_tag [4] = '{5'd6, 5'd7, 5'd8, 5'd9};
  bit               exc_exc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0]      exc_dat [4] = '{32'h1122_3344, 32'h0, 32'h1122_3344, 32'h0};
  logic [31:0]      req_seen[$];
  logic [2:0]       legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0]       bad_f3   [3] = '{3'd3, 3'd6, 3'd7};

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    set_issue(0, 0, 0, 0, 0);
    mem_ack = 1'b0; mem_rdata = '0; out_ack = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_size", mem_size, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_excp", out_excp, 0);
    tick;
    reset  = 1'b0;
    chk_en = 1;

    // Single LW, zero-wait memory
    tick; set_issue(1, 32'h100, 32'h4, 3'b010, 1);
    tick; set_issue(0, 0, 0, 0, 0);
    chk("lw_req", mem_req, 1);
    chk("lw_addr", mem_addr, 32'h104);
    chk("lw_size", mem_size, 2);
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    tick;
    chk("lw_valid", out_valid, 1);
    chk("lw_data", out_data, 32'hDEAD_BEEF);
    chk("lw_excp", out_excp, 0);
    chk("lw_tag", out_tag, 1);
    mem_ack = 0; out_ack = 1;
    tick; out_ack = 0;
    chk("lw_drain_valid", out_valid, 0);
    chk("lw_drain_count", count, 0);

    // Sign/zero extension of byte and half
    tick; set_issue(1, 32'h100, 32'h3, 3'b000, 2);
    tick; set_issue(1, 32'h100, 32'h3, 3'b100, 3); mem_ack = 1; mem_rdata = 32'h80FF_1234;
    tick; set_issue(1, 32'h100, 32'h2, 3'b001, 4);
    tick; set_issue(1, 32'h100, 32'h2, 3'b101, 5);
    tick; set_issue(0, 0, 0, 0, 0);
    tick; tick;
    out_ack = 1;
    for (int i = 0; i < 4; i++) begin
      chk("ext_valid", out_valid, 1);
      chk("ext_data", out_data, ext_exp[i]);
      chk("ext_tag", out_tag, 2 + i);
      tick;
    end
    out_ack = 0; mem_ack = 0;
    chk("ext_count", count, 0);

    // Exceptions stay in order and never reach memory
    mem_ack = 1; mem_rdata = 32'h1122_3344;
    req_seen.delete();
    for (int i = 0; i < 8; i++) begin
      tick;
      if (mem_req) req_seen.push_back(mem_addr);
      case (i)
        0: set_issue(1, 32'h200, 32'h0, 3'b010, 6);
        1: set_issue(1, 32'h200, 32'h1, 3'b001, 7);
        2: set_issue(1, 32'h200, 32'h4, 3'b010, 8);
        3: set_issue(1, 32'h208, 32'h0, 3'b011, 9);
        default: set_issue(0, 0, 0, 0, 0);
      endcase
    end
    chk("exc_nreq", req_seen.size(), 2);
    if (req_seen.size() == 2) begin
      chk("exc_req0", req_seen[0], 32'h200);
      chk("exc_req1", req_seen[1], 32'h204);
    end
    out_ack = 1;
    for (int i = 0; i < 4; i++) begin
      chk("exc_valid", out_valid, 1);
      chk("exc_tag", out_tag, exc_tag[i]);
      chk("exc_excp", out_excp, exc_exc[i]);
      chk("exc_data", out_data, exc_dat[i]);
      tick;
    end
    out_ack = 0; mem_ack = 0;

    // Full queue and backpressure
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 4; k++) begin
      tick; set_issue(1, 32'h400 + 4 * k, 32'h0, 3'b010, 10 + k);
    end
    tick; set_issue(1, 32'h410, 32'h0, 3'b010, 14);
    chk("full_ready", issue_ready, 0);
    chk("full_count", count, 4);
    out_ack = 1;
    tick; out_ack = 0;
    chk("full_retire_count", count, 3);
    chk("full_retire_ready", issue_ready, 1);
    tick; set_issue(0, 0, 0, 0, 0);
    chk("full_refill_count", count, 4);
    out_ack = 1;
    for (int k = 0; k < 4; k++) begin
      chk("full_tag", out_tag, 11 + k);
      tick;
    end
    out_ack = 0; mem_ack = 0;
    chk("full_empty", count, 0);

    // Memory stall: request holds until acked
    tick; set_issue(1, 32'h300, 32'h0, 3'b010, 15);
    tick; set_issue(0, 0, 0, 0, 0);
    for (int j = 0; j < 3; j++) begin
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, 32'h300);
      chk("stall_size", mem_size, 2);
      chk("stall_valid", out_valid, 0);
      tick;
    end
    chk("stall_req_last", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
    tick; mem_ack = 0;
    chk("stall_done", out_valid, 1);
    chk("stall_data", out_data, 32'h0BAD_F00D);
    out_ack = 1;
    tick; out_ack = 0;

    // Flush with a same-cycle ack
    tick; set_issue(1, 32'h500, 32'h0, 3'b010, 16);
    tick; set_issue(1, 32'h504, 32'h0, 3'b010, 17);
    tick; set_issue(1, 32'h508, 32'h0, 3'b010, 18);
    tick; set_issue(0, 0, 0, 0, 0);
    chk("fl_count_pre", count, 3);
    chk("fl_req_pre", mem_req, 1);
    flush = 1; mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    tick; flush = 0; mem_ack = 0;
    chk("fl_count", count, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_req", mem_req, 0);
    chk("fl_ready", issue_ready, 1);
    tick; tick;
    chk("fl_valid_later", out_valid, 0);

    // Async reset in the middle of a request; late ack ignored
    tick; set_issue(1, 32'h600, 32'h0, 3'b010, 19);
    tick; set_issue(1, 32'h604, 32'h0, 3'b010, 20);
    tick; set_issue(0, 0, 0, 0, 0);
    chk("ar_req_pre", mem_req, 1);
    reset = 1;
    #1;
    chk("ar_req_now", mem_req, 0);
    chk("ar_count_now", count, 0);
    chk("ar_valid_now", out_valid, 0);
    mem_ack = 1;
    tick; reset = 0;
    tick; mem_ack = 0;
    chk("ar_valid", out_valid, 0);
    chk("ar_count", count, 0);
    chk("ar_req", mem_req, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] b;
      tick;
      b = $urandom;
      if ($urandom_range(0, 1) == 0) b = b & ~32'h3;
      issue_valid  = ($urandom_range(0, 99) < 60);
      issue_base   = b;
      issue_imm    = 32'($urandom_range(0, 15)) - 32'd8;
      issue_funct3 = ($urandom_range(0, 99) < 85) ? legal_f3[$urandom_range(0, 4)]
                                                  : bad_f3[$urandom_range(0, 2)];
      issue_tag    = TAG_W'($urandom);
      mem_ack      = ($urandom_range(0, 99) < ((c < 1500) ? 65 : 90));
      mem_rdata    = $urandom;
      out_ack      = ($urandom_range(0, 99) < ((c < 1500) ? 70 : 40));
      flush        = ($urandom_range(0, 99) == 0);
      reset        = (c == 1700);
    end
    tick;
    reset = 0; flush = 0;
    set_issue(0, 0, 0, 0, 0);
    mem_ack = 0; out_ack = 0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
